div_sequencer: RTL
==================

# div_sequencer

Iterative multi-cycle divide/remainder unit with its own sequencing FSM. It replaces the single-cycle `/` and `%` operators in the execute stage. Execute hands off a div/rem-class instruction through a valid/ready request and holds the pipeline via `busy` while the unit iterates. The unit then returns the sign-corrected result and destination register through a valid/ready response. It implements RISC-V M-extension semantics for all eight div/rem variants, including divide-by-zero and signed overflow.

## Interface
Parameters:
- XLEN, 64, datapath width; W-variants operate on the low 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- req_valid  in  1  execute presents a div/rem operation
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  0 div, 1 divu, 2 rem, 3 remu, 4 divw, 5 divuw, 6 remw, 7 remuw
- req_rs1  in  XLEN  dividend (forwarded value)
- req_rs2  in  XLEN  divisor (forwarded value)
- req_rd  in  6  destination register tag
- flush  in  1  branch/redirect kill; aborts any in-flight operation
- busy  out  1  state != IDLE; drives the execute stall toward decode
- resp_valid  out  1  result available; high only in DONE
- resp_ready  in  1  memory-stage side accepts result
- resp_result  out  XLEN  final quotient or remainder
- resp_rd  out  6  tag captured at accept

## Operation
- States: IDLE, DIV, FIX, DONE.
- Accept: req_valid && req_ready && !flush at a clock edge. On accept, the unit latches op, rd, and operand magnitudes.
- W ops: take low 32 bits of each operand, sign-extended for divw/remw and zero-extended for divuw/remuw.
- Signed ops (div, rem, divw, remw): take absolute values and record neg_q = sign(a)^sign(b) and neg_r = sign(a).
- Unsigned ops: neg_q = neg_r = 0.
- Special cases, detected at accept (IDLE→DONE directly, no iteration):
  - divisor == 0: quotient = all ones; remainder = dividend (W: low 32 sign-extended).
  - Signed overflow (div/rem: 0x8000…0000 / −1; divw/remw: 32-bit 0x80000000 / −1): quotient = dividend (W: sign-extended); remainder = 0.
- IDLE→DIV otherwise.
  - N = 64 for ops 0-3 and N = 32 for ops 4-7.
  - The iteration counter is cleared.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - Each cycle: rem = {rem, next dividend bit}. If rem ≥ divisor, subtract and shift in 1; else shift in 0.
  - The remainder register is XLEN+1 bits wide.
  - After N iterations, DIV→FIX.
- FIX:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select the quotient or remainder by op.
  - For W ops, sign-extend bit 31 to 64 bits; this includes divuw/remuw.
  - Load resp_result. FIX→DONE.
- DONE: resp_valid=1 and resp_result/resp_rd held stable. On resp_ready, DONE→IDLE.
- flush: on any edge where flush=1, the next state is IDLE and resp_valid drops.
  - flush has priority over accept, iteration, and response handshake.
  - A response killed by flush is never delivered.

## Timing
- Reset values:
  - state IDLE, resp_valid 0, resp_result 0, resp_rd 0, busy 0.
  - req_ready 1 (combinational from state), counter 0.
- Latency, where A is the accept edge:
  - Normal ops: resp_valid rises at edge A+N+1 (A+65 for 64-bit, A+33 for W ops).
  - Special cases: resp_valid rises at edge A.
- Throughput: one operation in flight. req_ready is low from edge A until the edge after the response is taken.
- Back-to-back requests: a new request is accepted no earlier than the first cycle with state IDLE after the resp_valid && resp_ready edge. There is no same-cycle bypass.
- Backpressure: with resp_ready=0, DONE holds indefinitely and outputs do not change.
- busy is combinational from state; it is high in the same cycle resp_valid is high.
- Reset mid-operation: identical to flush, and also clears the data registers to 0.

## Test plan
- div 100 / 7 (op 0): resp_result=14 exactly 65 edges after accept, resp_rd matches req_rd; rem (op 2) of same operands gives 2.
- rem −7 / 2 (op 2): result 0xFFFF_FFFF_FFFF_FFFF (−1); div gives −3.
- divu 5 / 0 (op 1): all-ones result at the accept edge; remu 5 / 0 (op 3): result 5.
- div 0x8000_0000_0000_0000 / −1: result 0x8000_0000_0000_0000, 0-cycle iteration; divw rs1=0x1_8000_0000, rs2=−1: 0xFFFF_FFFF_8000_0000.
- divuw rs1=0xFFFF_FFFF_FFFF_FFFE, rs2=1: result 0xFFFF_FFFF_FFFF_FFFE (sign-extended from bit 31), latency 33.
- flush asserted 10 cycles into a 64-bit div: next edge IDLE, resp_valid never rises. Then hold resp_ready=0 for 5 cycles on a fresh op: result and rd stable, and req_ready stays 0 until handshake.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative restoring divide/remainder unit (RISC-V M semantics, all 8 div/rem ops).
// One quotient bit per cycle; special cases (divide-by-zero, signed overflow) resolve at accept.
module div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [5:0]      req_rd,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [5:0]      resp_rd
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // DIV   | restoring iteration, one quotient bit per cycle
  // FIX   | sign correction, result select, W sign-extension
  // DONE  | response valid, held until resp_ready
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_t state, next_state;

  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;
  logic            is_w_q, is_rem_q, neg_q, neg_r;

  logic            accept;
  logic            in_w, in_signed;
  logic [XLEN-1:0] a_sx32, b_sx32, opa, opb, abs_a, abs_b;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] special_res;

  logic [XLEN+1:0] shifted, trial;
  logic            q_bit;
  logic [XLEN:0]   rem_nxt;
  logic            last_iter;
  logic [XLEN-1:0] q_fix, r_fix, sel, fix_res;

  assign accept = req_valid && (state == IDLE) && !flush;

  // Operand conditioning and special-case detection for the request on the bus.
  always_comb begin
    in_w      = req_op[2];
    in_signed = !req_op[0];
    a_sx32    = {{(XLEN-32){req_rs1[31]}}, req_rs1[31:0]};
    b_sx32    = {{(XLEN-32){req_rs2[31]}}, req_rs2[31:0]};
    opa       = req_rs1;
    opb       = req_rs2;
    if (in_w) begin
      opa = in_signed ? a_sx32 : {{(XLEN-32){1'b0}}, req_rs1[31:0]};
      opb = in_signed ? b_sx32 : {{(XLEN-32){1'b0}}, req_rs2[31:0]};
    end
    abs_a    = (in_signed && opa[XLEN-1]) ? -opa : opa;
    abs_b    = (in_signed && opb[XLEN-1]) ? -opb : opb;
    div_zero = (opb == '0);
    ovf      = in_signed && (opb == '1) && (in_w ? (opa == MIN_W) : (opa == MIN_X));
    special  = div_zero || ovf;
    special_res = '0;
    if (div_zero)
      special_res = req_op[1] ? (in_w ? a_sx32 : req_rs1) : '1;
    else if (ovf)
      special_res = req_op[1] ? '0 : (in_w ? a_sx32 : req_rs1);
  end

  // Restoring step; the extra top bit of the trial difference is the borrow.
  always_comb begin
    shifted   = {rem, dvd[XLEN-1]};
    trial     = shifted - {2'b00, dsr};
    q_bit     = !trial[XLEN+1];
    rem_nxt   = q_bit ? trial[XLEN:0] : shifted[XLEN:0];
    last_iter = (cnt == (is_w_q ? CW'(XLEN/2 - 1) : CW'(XLEN - 1)));
  end

  always_comb begin
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    sel     = is_rem_q ? r_fix : q_fix;
    fix_res = is_w_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = special ? DONE : DIV;
      DIV:  if (last_iter) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      is_w_q      <= 1'b0;
      is_rem_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      resp_result <= '0;
      resp_rd     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // W dividends are left-aligned so the MSB-first shift works for both widths.
          dvd      <= in_w ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
          dsr      <= abs_b;
          rem      <= '0;
          cnt      <= '0;
          is_w_q   <= in_w;
          is_rem_q <= req_op[1];
          neg_q    <= in_signed && (opa[XLEN-1] ^ opb[XLEN-1]);
          neg_r    <= in_signed && opa[XLEN-1];
          resp_rd  <= req_rd;
          if (special) resp_result <= special_res;
        end
        DIV: if (!flush) begin
          rem <= rem_nxt;
          dvd <= {dvd[XLEN-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: if (!flush) resp_result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
